fwrisc_csr_rmw: RTL and testbench
=================================

FWRISC_CSR_RMW -- requirements
Module: fwrisc_csr_rmw

Interface
REQ-001 SHALL have parameter ENABLE_IMM, default 1: 1 = immediate forms supported; 0 = req_imm_en ignored and treated as 0.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  CSR operation request.
REQ-005 SHALL have port req_ready  output  1  high only in IDLE; accept when req_valid && req_ready.
REQ-006 SHALL have port req_op  input  2  01=RW, 10=RS (set bits), 11=RC (clear bits), 00=reserved, treated as RW.
REQ-007 SHALL have port req_csr  input  6  regfile CSR address, 0x20-0x3F.
REQ-008 SHALL have port req_rs1  input  6  source GPR address.
REQ-009 SHALL have port req_rd  input  6  destination GPR address.
REQ-010 SHALL have port req_imm_en  input  1  source is zero-extended req_imm instead of GPR.
REQ-011 SHALL have port req_imm  input  5  immediate source.
REQ-012 SHALL have ports ra_raddr output 6, ra_rdata input 32, rb_raddr output 6, rb_rdata input 32: combinational regfile read ports.
REQ-013 SHALL have ports rd_waddr output 6, rd_wdata output 32, rd_wen output 1: regfile write port.
REQ-014 SHALL have ports rsp_valid output 1, rsp_illegal output 1: completion pulse and status.

Function
REQ-015 SHALL implement FSM IDLE -> READ -> WCSR -> WRD -> RSP -> IDLE, one cycle per state, no stalls.
REQ-016 SHALL latch req_op/csr/rs1/rd/imm_en/imm on acceptance; request inputs are ignored outside IDLE.
REQ-017 SHALL, in READ, drive ra_raddr=rs1 and rb_raddr=csr, and capture old=rb_rdata and src=(imm_en ? {27'b0,imm} : ra_rdata).
REQ-018 SHALL compute new = src (RW), old|src (RS), old&~src (RC), 32 bits, no carry.
REQ-019 SHALL, in WCSR, assert rd_wen with rd_waddr=csr and rd_wdata=new, unless suppressed.
REQ-020 SHALL suppress the CSR write for RS/RC when the source specifier is zero: rs1==0 if imm_en=0, imm==0 if imm_en=1. RW always writes.
REQ-021 SHALL, in WRD, assert rd_wen with rd_waddr=rd and rd_wdata=old, unless rd==0.
REQ-022 SHALL pulse rsp_valid for exactly one cycle in RSP; latency is fixed at 4 cycles after acceptance, including when writes are suppressed.
REQ-023 SHALL drive rd_wen=0, rd_waddr=0, rd_wdata=0, ra_raddr=0 and rb_raddr=0 in IDLE, and in every state whose write is suppressed.
REQ-024 SHALL allow a new request to be accepted in the cycle after RSP; back-to-back throughput is 1 op per 5 cycles.
REQ-025 SHALL write to the CSR when rd equals csr, and WRD then overwrites that address with old; writes are not merged.

Reset
REQ-026 SHALL, on reset assertion at any state, go to IDLE immediately and clear all latched fields.
REQ-027 SHALL hold these output values during reset: req_ready=1, rsp_valid=0, rsp_illegal=0, rd_wen=0, all addresses and data 0.
REQ-028 SHALL issue no write and no rsp_valid for an operation aborted by reset.

Configuration
REQ-029 SHALL, with FWRISC_CSR_RO_CHECK_EN defined, flag an unsuppressed write to csr[5:3]==3'b100 (read-only range) as illegal, under these rules:
- both WCSR and WRD writes are suppressed;
- rsp_illegal=1 is driven alongside rsp_valid.
REQ-030 SHALL, without FWRISC_CSR_RO_CHECK_EN, issue all writes normally and tie rsp_illegal to 0.

Structure
REQ-031 SHALL place the following in shared package fwrisc_csr_pkg:
- req_op encodings;
- FSM state enum;
- RO-range constant 3'b100.
REQ-032 SHALL be a single module with no sub-modules; the new-value computation is an inline function.

Verification
REQ-033 SHALL cover RW: CSR 0x3A=0x1234, x5=0xA5A5, rd=x7 -> rd_wen to 0x3A with 0xA5A5 in cycle 2, rd_wen to 7 with 0x1234 in cycle 3, rsp_valid in cycle 4.
REQ-034 SHALL cover RS/RC with imm: CSR=0xF0, RS imm=0x0F -> new 0xFF; RC imm=0x30 -> new 0xC0.
REQ-035 SHALL cover suppression: RS with rs1=0 and rd=0 -> no rd_wen at all, rsp_valid still in cycle 4.
REQ-036 SHALL cover RO check (macro on): RW to 0x21 -> no writes, rsp_illegal=1; macro off -> write to 0x21 issued, rsp_illegal=0.
REQ-037 SHALL cover reset in WCSR: assert reset -> outputs zeroed immediately, no rsp_valid, req_ready=1 after release.
REQ-038 SHALL cover back-to-back: req_valid held high for two ops -> second acceptance exactly 5 cycles after the first.

Source files
------------

// File: rtl/fwrisc_csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwrisc_csr_pkg
//  Description : Shared types and constants for the CSR read-modify-write
//                sequencer (operation encodings, FSM states, RO range).
//  Revision    : 1.0 - initial release
// ============================================================================
package fwrisc_csr_pkg;

    // CSR operation encodings carried on req_op
    typedef enum logic [1:0] {
        CSR_OP_RSVD = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // Sequencer states, one cycle each
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WCSR = 3'd2,
        ST_WRD  = 3'd3,
        ST_RSP  = 3'd4
    } csr_state_e;

    // csr[5:3] value marking the read-only CSR window
    localparam logic [2:0] CSR_RO_RANGE = 3'b100;

endpackage
`default_nettype wire

// File: rtl/fwrisc_csr_rmw.sv
`default_nettype none
// ============================================================================
//  Module      : fwrisc_csr_rmw
//  Description : CSR read-modify-write sequencer working on a shared register
//                file: reads GPR source and old CSR value, writes the new CSR
//                value, writes the old value to rd, then signals completion.
//                Optional macro FWRISC_CSR_RO_CHECK_EN enables rejection of
//                writes into the read-only CSR window.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwrisc_csr_rmw
    import fwrisc_csr_pkg::*;
#(
    parameter int unsigned ENABLE_IMM = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [5:0]  req_csr,
    input  logic [5:0]  req_rs1,
    input  logic [5:0]  req_rd,
    input  logic        req_imm_en,
    input  logic [4:0]  req_imm,
    output logic [5:0]  ra_raddr,
    input  logic [31:0] ra_rdata,
    output logic [5:0]  rb_raddr,
    input  logic [31:0] rb_rdata,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        rd_wen,
    output logic        rsp_valid,
    output logic        rsp_illegal
);

    csr_state_e  state_q,  state_d;
    csr_op_e     op_q,     op_d;
    logic [5:0]  csr_q,    csr_d;
    logic [5:0]  rs1_q,    rs1_d;
    logic [5:0]  rd_q,     rd_d;
    logic        imm_en_q, imm_en_d;
    logic [4:0]  imm_q,    imm_d;
    logic [31:0] old_q,    old_d;
    logic [31:0] src_q,    src_d;

    logic        w_src_nz;
    logic        w_csr_wr_req;
    logic        w_illegal;
    logic        w_csr_we;
    logic        w_rd_we;

    // New CSR value: plain bitwise combine, no arithmetic
    function automatic logic [31:0] csr_new_val(
        input csr_op_e     op,
        input logic [31:0] old_v,
        input logic [31:0] src_v
    );
        case (op)
            CSR_OP_RS: return old_v | src_v;
            CSR_OP_RC: return old_v & ~src_v;
            default:   return src_v;
        endcase
    endfunction

    // Decide which of the two writes actually happen for the latched op
    always_comb begin
        w_src_nz     = imm_en_q ? (imm_q != 5'd0) : (rs1_q != 6'd0);
        w_csr_wr_req = (op_q == CSR_OP_RW) || (op_q == CSR_OP_RSVD) || w_src_nz;
`ifdef FWRISC_CSR_RO_CHECK_EN
        w_illegal    = w_csr_wr_req && (csr_q[5:3] == CSR_RO_RANGE);
`else
        w_illegal    = 1'b0;
`endif
        w_csr_we     = w_csr_wr_req && !w_illegal;
        w_rd_we      = (rd_q != 6'd0) && !w_illegal;
    end

    // Next-state, field capture and per-state outputs (all zero unless used)
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        csr_d       = csr_q;
        rs1_d       = rs1_q;
        rd_d        = rd_q;
        imm_en_d    = imm_en_q;
        imm_d       = imm_q;
        old_d       = old_q;
        src_d       = src_q;
        req_ready   = 1'b0;
        ra_raddr    = 6'd0;
        rb_raddr    = 6'd0;
        rd_wen      = 1'b0;
        rd_waddr    = 6'd0;
        rd_wdata    = 32'd0;
        rsp_valid   = 1'b0;
        rsp_illegal = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d     = csr_op_e'(req_op);
                    csr_d    = req_csr;
                    rs1_d    = req_rs1;
                    rd_d     = req_rd;
                    imm_en_d = (ENABLE_IMM != 0) ? req_imm_en : 1'b0;
                    imm_d    = req_imm;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                ra_raddr = rs1_q;
                rb_raddr = csr_q;
                old_d    = rb_rdata;
                src_d    = imm_en_q ? {27'd0, imm_q} : ra_rdata;
                state_d  = ST_WCSR;
            end
            ST_WCSR: begin
                if (w_csr_we) begin
                    rd_wen   = 1'b1;
                    rd_waddr = csr_q;
                    rd_wdata = csr_new_val(op_q, old_q, src_q);
                end
                state_d = ST_WRD;
            end
            ST_WRD: begin
                if (w_rd_we) begin
                    rd_wen   = 1'b1;
                    rd_waddr = rd_q;
                    rd_wdata = old_q;
                end
                state_d = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid   = 1'b1;
                rsp_illegal = w_illegal;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-field registers; reset aborts any op in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= CSR_OP_RSVD;
            csr_q    <= 6'd0;
            rs1_q    <= 6'd0;
            rd_q     <= 6'd0;
            imm_en_q <= 1'b0;
            imm_q    <= 5'd0;
            old_q    <= 32'd0;
            src_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            csr_q    <= csr_d;
            rs1_q    <= rs1_d;
            rd_q     <= rd_d;
            imm_en_q <= imm_en_d;
            imm_q    <= imm_d;
            old_q    <= old_d;
            src_q    <= src_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_csr_rmw.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fwrisc_csr_rmw
//  Description : Self-checking bench for fwrisc_csr_rmw: register-file
//                environment, transaction-level reference model, per-cycle
//                output compare, directed and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwrisc_csr_rmw;

    localparam int ENABLE_IMM = 1;
`ifdef FWRISC_CSR_RO_CHECK_EN
    localparam bit RO_CHK = 1'b1;
`else
    localparam bit RO_CHK = 1'b0;
`endif

    typedef struct packed {
        logic        rdy;
        logic [5:0]  ra;
        logic [5:0]  rb;
        logic        wen;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic        rv;
        logic        ri;
    } outs_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [5:0]  req_csr = 6'd0;
    logic [5:0]  req_rs1 = 6'd0;
    logic [5:0]  req_rd = 6'd0;
    logic        req_imm_en = 1'b0;
    logic [4:0]  req_imm = 5'd0;
    logic [5:0]  ra_raddr, rb_raddr, rd_waddr;
    logic [31:0] ra_rdata, rb_rdata, rd_wdata;
    logic        rd_wen, rsp_valid, rsp_illegal;

    // Environment register file (as seen by the DUT) and model copy
    logic [31:0] rf  [64];
    logic [31:0] mdl [64];
    logic [31:0] pre_val [64];
    int          pre_seq  = 0;
    int          pre_done = 0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_q [$];

    // Reference-model transaction state
    int          age = -1;
    logic [1:0]  m_op;
    logic [5:0]  m_csr, m_rs1, m_rd;
    logic        m_immen;
    logic [4:0]  m_imm;
    logic [31:0] m_old, m_src, m_new;
    bit          m_csr_we, m_rd_we, m_ill;

    // DUT write seen at negedge, committed to rf at the following posedge
    bit          pend;
    logic [5:0]  pend_a;
    logic [31:0] pend_d;

    assign ra_rdata = rf[ra_raddr];
    assign rb_rdata = rf[rb_raddr];

    always #5 clock = ~clock;

    fwrisc_csr_rmw #(.ENABLE_IMM(ENABLE_IMM)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_csr     (req_csr),
        .req_rs1     (req_rs1),
        .req_rd      (req_rd),
        .req_imm_en  (req_imm_en),
        .req_imm     (req_imm),
        .ra_raddr    (ra_raddr),
        .ra_rdata    (ra_rdata),
        .rb_raddr    (rb_raddr),
        .rb_rdata    (rb_rdata),
        .rd_waddr    (rd_waddr),
        .rd_wdata    (rd_wdata),
        .rd_wen      (rd_wen),
        .rsp_valid   (rsp_valid),
        .rsp_illegal (rsp_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Whole-transaction outcome computed at acceptance from the model's regfile
    task automatic model_accept();
        m_op    = req_op;
        m_csr   = req_csr;
        m_rs1   = req_rs1;
        m_rd    = req_rd;
        m_immen = (ENABLE_IMM != 0) ? req_imm_en : 1'b0;
        m_imm   = req_imm;
        m_old   = mdl[m_csr];
        m_src   = m_immen ? 32'(m_imm) : mdl[m_rs1];
        if (m_op == 2'b10)      m_new = m_old | m_src;
        else if (m_op == 2'b11) m_new = m_old & ~m_src;
        else                    m_new = m_src;
        m_csr_we = (m_op == 2'b01) || (m_op == 2'b00) ||
                   (m_immen ? (m_imm != 0) : (m_rs1 != 0));
        m_ill    = RO_CHK && m_csr_we && (m_csr >= 6'h20) && (m_csr <= 6'h27);
        if (m_ill) m_csr_we = 1'b0;
        m_rd_we  = (m_rd != 0) && !m_ill;
    endtask

    // Model timeline: acceptance, CSR write after 2 cycles, rd write after 3, done after 4
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (pre_seq != pre_done) begin
                for (int i = 0; i < 64; i++) begin
                    rf[i]  = pre_val[i];
                    mdl[i] = pre_val[i];
                end
                pre_done = pre_seq;
            end
            if (reset) begin
                age = -1;
            end else begin
                cyc++;
                if (pend && pend_a != 6'd0) rf[pend_a] = pend_d;
                case (age)
                    -1: if (req_valid) begin model_accept(); age = 1; end
                    2: begin if (m_csr_we) mdl[m_csr] = m_new; age = 3; end
                    3: begin if (m_rd_we)  mdl[m_rd]  = m_old; age = 4; end
                    4: age = -1;
                    default: age = age + 1;
                endcase
            end
        end
    end

    // Per-cycle output compare against the model timeline
    initial begin
        outs_t e;
        outs_t a;
        forever begin
            @(negedge clock);
            e = '0;
            e.rdy = (age == -1);
            case (age)
                1: begin e.ra = m_rs1; e.rb = m_csr; end
                2: if (m_csr_we) begin e.wen = 1'b1; e.wa = m_csr; e.wd = m_new; end
                3: if (m_rd_we)  begin e.wen = 1'b1; e.wa = m_rd;  e.wd = m_old; end
                4: begin e.rv = 1'b1; e.ri = m_ill; end
                default: ;
            endcase
            a = {req_ready, ra_raddr, rb_raddr, rd_wen, rd_waddr, rd_wdata, rsp_valid, rsp_illegal};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs@cyc%0d: got rdy=%b ra=%h rb=%h wen=%b wa=%h wd=%h rv=%b ri=%b, required rdy=%b ra=%h rb=%h wen=%b wa=%h wd=%h rv=%b ri=%b",
                         cyc, a.rdy, a.ra, a.rb, a.wen, a.wa, a.wd, a.rv, a.ri,
                         e.rdy, e.ra, e.rb, e.wen, e.wa, e.wd, e.rv, e.ri);
            end
            pend   = rd_wen && !reset;
            pend_a = rd_waddr;
            pend_d = rd_wdata;
            if (req_valid && req_ready && !reset) acc_q.push_back(cyc);
        end
    end

    // Present one request and return just after it is accepted (cycle 1 begins)
    task automatic issue(input logic [1:0] op, input logic [5:0] csr, input logic [5:0] rs1,
                         input logic [5:0] rd, input logic ie, input logic [4:0] imm);
        int n;
        @(posedge clock); #1;
        req_op = op; req_csr = csr; req_rs1 = rs1; req_rd = rd;
        req_imm_en = ie; req_imm = imm; req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clock);
            if (req_ready) break;
            n++;
            if (n > 20) begin
                n_vec++; n_err++;
                $display("FAIL accept_timeout: got no acceptance, required acceptance within 20 cycles");
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_pre();
        pre_seq++;
        @(posedge clock); #1;
    endtask

    initial begin
        int n;
        int s;
        for (int i = 0; i < 64; i++) pre_val[i] = 32'd0;
        pre_val[6'h05] = 32'h0000_A5A5;
        pre_val[6'h06] = 32'h0000_0030;
        pre_val[6'h3A] = 32'h0000_1234;
        pre_val[6'h30] = 32'h0000_00F0;
        pre_val[6'h31] = 32'h0000_00F0;
        pre_val[6'h3B] = 32'h0000_0055;
        pre_seq = 1;

        repeat (3) @(negedge clock);
        chk("rst_ready",   32'(req_ready),   32'd1);
        chk("rst_rsp",     32'(rsp_valid),   32'd0);
        chk("rst_illegal", 32'(rsp_illegal), 32'd0);
        chk("rst_wen",     32'(rd_wen),      32'd0);
        chk("rst_waddr",   32'(rd_waddr),    32'd0);
        chk("rst_wdata",   rd_wdata,         32'd0);
        chk("rst_raddr",   32'({ra_raddr, rb_raddr}), 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        // RW: CSR 0x3A=0x1234, x5=0xA5A5, rd=x7
        issue(2'b01, 6'h3A, 6'd5, 6'd7, 1'b0, 5'd0);
        @(negedge clock);
        chk("rw_c1_ra", 32'(ra_raddr), 32'h05);
        chk("rw_c1_rb", 32'(rb_raddr), 32'h3A);
        @(negedge clock);
        chk("rw_c2_wen",  32'(rd_wen),   32'd1);
        chk("rw_c2_addr", 32'(rd_waddr), 32'h3A);
        chk("rw_c2_data", rd_wdata,      32'h0000_A5A5);
        @(negedge clock);
        chk("rw_c3_wen",  32'(rd_wen),   32'd1);
        chk("rw_c3_addr", 32'(rd_waddr), 32'h07);
        chk("rw_c3_data", rd_wdata,      32'h0000_1234);
        @(negedge clock);
        chk("rw_c4_rsp",  32'(rsp_valid), 32'd1);

        // RS imm 0x0F on 0xF0 -> 0xFF
        issue(2'b10, 6'h30, 6'd0, 6'd0, 1'b1, 5'h0F);
        repeat (2) @(negedge clock);
        chk("rs_imm_addr", 32'(rd_waddr), 32'h30);
        chk("rs_imm_data", rd_wdata,      32'h0000_00FF);
        // RC with x6=0x30 on 0xF0 -> 0xC0
        issue(2'b11, 6'h31, 6'd6, 6'd0, 1'b0, 5'd0);
        repeat (2) @(negedge clock);
        chk("rc_reg_data", rd_wdata, 32'h0000_00C0);
        // RC imm 0x10 on 0xFF -> 0xEF
        issue(2'b11, 6'h30, 6'd0, 6'd0, 1'b1, 5'h10);
        repeat (2) @(negedge clock);
        chk("rc_imm_data", rd_wdata, 32'h0000_00EF);

        // RS with rs1=x0 and rd=x0: nothing written, response still at cycle 4
        issue(2'b10, 6'h3A, 6'd0, 6'd0, 1'b0, 5'd0);
        repeat (2) @(negedge clock);
        chk("sup_c2_wen", 32'(rd_wen), 32'd0);
        @(negedge clock);
        chk("sup_c3_wen", 32'(rd_wen), 32'd0);
        @(negedge clock);
        chk("sup_c4_rsp", 32'(rsp_valid), 32'd1);

        // RW into the read-only window
        issue(2'b01, 6'h21, 6'd5, 6'd9, 1'b0, 5'd0);
        repeat (2) @(negedge clock);
        chk("ro_c2_wen", 32'(rd_wen), RO_CHK ? 32'd0 : 32'd1);
        @(negedge clock);
        chk("ro_c3_wen", 32'(rd_wen), RO_CHK ? 32'd0 : 32'd1);
        @(negedge clock);
        chk("ro_c4_rsp", 32'(rsp_valid),   32'd1);
        chk("ro_c4_ill", 32'(rsp_illegal), RO_CHK ? 32'd1 : 32'd0);

        // Reset asserted during the CSR write cycle
        issue(2'b01, 6'h3B, 6'd5, 6'd8, 1'b0, 5'd0);
        repeat (2) @(negedge clock);
        chk("abort_c2_wen", 32'(rd_wen), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_wen",   32'(rd_wen),    32'd0);
        chk("abort_wdata", rd_wdata,       32'd0);
        chk("abort_waddr", 32'(rd_waddr),  32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp",   32'(rsp_valid), 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("abort_no_write", rf[6'h3B], 32'h0000_0055);

        // Back-to-back: valid held high across two operations
        @(posedge clock); #1;
        req_op = 2'b01; req_csr = 6'h3C; req_rs1 = 6'd5; req_rd = 6'd10;
        req_imm_en = 1'b0; req_valid = 1'b1;
        s = acc_q.size();
        n = 0;
        while (acc_q.size() < s + 2 && n < 30) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock); #1 req_valid = 1'b0;
        if (acc_q.size() >= s + 2)
            chk("b2b_spacing", 32'(acc_q[s+1] - acc_q[s]), 32'd5);
        else begin
            n_vec++; n_err++;
            $display("FAIL b2b_timeout: got %0d acceptances, required 2", acc_q.size() - s);
        end
        repeat (8) @(negedge clock);

        // Randomized phase over a randomized register file
        for (int i = 1; i < 64; i++) pre_val[i] = $urandom;
        wait_pre();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clock); #1;
            req_valid  = ($urandom_range(0, 9) < 6);
            req_op     = 2'($urandom_range(0, 3));
            req_csr    = {1'b1, 5'($urandom_range(0, 31))};
            req_rs1    = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            req_imm_en = 1'($urandom_range(0, 1));
            req_imm    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0:       req_rd = 6'd0;
                1:       req_rd = req_csr;
                default: req_rd = 6'($urandom_range(0, 63));
            endcase
        end
        @(posedge clock); #1 req_valid = 1'b0;
        repeat (10) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
